// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its issue sequencer: opcodes,
// sequencer states and the buffered command record.
package alu_pkg;

   localparam int WIDTH = 8;

   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      AND  = 4'd2,
      OR   = 4'd3,
      XOR  = 4'd4,
      NOTB = 4'd5,
      ANDN = 4'd6,
      ASR  = 4'd7,
      LSR  = 4'd8,
      LSL  = 4'd9
   } alu_op_e;

   localparam logic [3:0] OP_LAST = 4'b1001;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_CAPTURE,
      S_RESP
   } seq_state_e;

   typedef struct packed {
      logic [3:0]       op;
      logic             use_acc;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } alu_cmd_t;

   function automatic logic op_is_legal(input logic [3:0] op);
      return op <= OP_LAST;
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous command buffer; pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  logic     pop,
   input  alu_cmd_t wr_data,
   output alu_cmd_t rd_data,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   alu_cmd_t       mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Storage is not cleared on reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the combinational ALU: buffers commands, drives registered
// operands, captures the result and returns it in order with an accumulator.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH      = alu_pkg::WIDTH,
   parameter int FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic             cmd_use_acc,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_res,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [WIDTH-1:0] acc,
   output logic             busy
);

   seq_state_e state;
   seq_state_e state_nxt;
   alu_cmd_t   push_cmd;
   alu_cmd_t   head_cmd;
   alu_cmd_t   cur_cmd;
   logic       fifo_full;
   logic       fifo_empty;
   logic       push;
   logic       pop;

   assign push_cmd  = '{op: cmd_op, use_acc: cmd_use_acc, a: cmd_a, b: cmd_b};
   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && cmd_ready;
   assign rsp_valid = (state == S_RESP);
   assign busy      = (state != S_IDLE) || !fifo_empty;

   alu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (push_cmd),
      .rd_data (head_cmd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A response handshake can pop the next command directly, skipping IDLE.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = S_DRIVE;
            end
         end
         S_DRIVE:   state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = S_RESP;
         S_RESP: begin
            if (rsp_ready) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = S_DRIVE;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Operand a is chosen in DRIVE so a chained command sees the result of the
   // command issued just before it, not the accumulator at push time.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_cmd    <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         rsp_data   <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
         acc        <= '0;
      end else begin
         if (pop) begin
            cur_cmd <= head_cmd;
         end
         if (state == S_DRIVE) begin
            alu_a      <= cur_cmd.use_acc ? acc : cur_cmd.a;
            alu_b      <= cur_cmd.b;
            alu_opcode <= cur_cmd.op;
         end
         if (state == S_CAPTURE) begin
            if (op_is_legal(alu_opcode)) begin
               rsp_data <= alu_res;
               rsp_zero <= (alu_res == '0);
               rsp_err  <= 1'b0;
               acc      <= alu_res;
            end else begin
               rsp_data <= '1;
               rsp_zero <= 1'b0;
               rsp_err  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU on the alu_* port and an
// in-order scoreboard that tracks the accumulator from accepted commands.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int NRAND = 80;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_op = '0;
   logic       cmd_use_acc = 1'b0;
   logic [7:0] cmd_a = '0;
   logic [7:0] cmd_b = '0;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_opcode;
   logic [7:0] alu_res;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_data;
   logic       rsp_zero;
   logic       rsp_err;
   logic [7:0] acc;
   logic       busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string      name;
      logic [3:0] op;
      logic       use_acc;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_data;
      logic       exp_zero;
      logic       exp_err;
      logic [7:0] exp_acc;
   } vec_t;

   typedef struct packed {
      logic [7:0] data;
      logic       zero;
      logic       err;
      logic [7:0] acc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] model_acc = '0;

   always #5 clk = ~clk;

   alu_op_sequencer #(
      .WIDTH      (8),
      .FIFO_DEPTH (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_use_acc (cmd_use_acc),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_opcode  (alu_opcode),
      .alu_res     (alu_res),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_zero    (rsp_zero),
      .rsp_err     (rsp_err),
      .acc         (acc),
      .busy        (busy)
   );

   function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ~b;
         4'd6:    return a & ~b;
         4'd7:    return {a[7], a[7:1]};
         4'd8:    return {1'b0, a[7:1]};
         4'd9:    return {a[6:0], 1'b0};
         default: return 8'h00;
      endcase
   endfunction

   always_comb alu_res = alu_fn(alu_opcode, alu_a, alu_b);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic void model_accept(input logic [3:0] op, input logic use_acc, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] opa;
      logic [7:0] res;
      exp_t       e;
      opa = use_acc ? model_acc : a;
      if (op <= 4'd9) begin
         res       = alu_fn(op, opa, b);
         model_acc = res;
         e         = '{data: res, zero: (res == 8'h00), err: 1'b0, acc: res};
      end else begin
         e = '{data: 8'hFF, zero: 1'b0, err: 1'b1, acc: model_acc};
      end
      exp_q.push_back(e);
   endfunction

   // Scoreboard: sampled on the falling edge, mirrors the handshakes of the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         model_acc = '0;
      end else begin
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL sb_unexpected_rsp: got data 0x%0h, expected no response", rsp_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput("sb_data", rsp_data, e.data);
               checkOutput("sb_zero", rsp_zero, e.zero);
               checkOutput("sb_err", rsp_err, e.err);
               checkOutput("sb_acc", acc, e.acc);
            end
         end
         if (cmd_valid && cmd_ready) begin
            model_accept(cmd_op, cmd_use_acc, cmd_a, cmd_b);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Caller is just after a rising edge; returns just after the accepting edge.
   task automatic applyStimulus(input logic [3:0] op, input logic use_acc, input logic [7:0] a, input logic [7:0] b);
      int n;
      cmd_op      = op;
      cmd_use_acc = use_acc;
      cmd_a       = a;
      cmd_b       = b;
      cmd_valid   = 1'b1;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         tests++;
         fails++;
         $display("[TB] FAIL cmd_accept_timeout: cmd_ready got 0, expected 1 within 100 cycles");
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run_vector(input vec_t v);
      int lat;
      applyStimulus(v.op, v.use_acc, v.a, v.b);
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) break;
      end
      checkOutput({v.name, "_latency"}, lat, 4);
      checkOutput({v.name, "_data"}, rsp_data, v.exp_data);
      checkOutput({v.name, "_zero"}, rsp_zero, v.exp_zero);
      checkOutput({v.name, "_err"}, rsp_err, v.exp_err);
      checkOutput({v.name, "_acc"}, acc, v.exp_acc);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input string name, input logic [7:0] exp_data);
      int n;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_valid"}, rsp_valid, 1);
      checkOutput({name, "_data"}, rsp_data, exp_data);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t vecs[16];
      int   seen;
      int   sent;
      logic accepted;

      vecs[0]  = '{"and_f0_3c",   AND,   1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 8'h30};
      vecs[1]  = '{"add_05_03",   ADD,   1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 8'h08};
      vecs[2]  = '{"lsl_chain",   LSL,   1'b1, 8'h99, 8'h77, 8'h10, 1'b0, 1'b0, 8'h10};
      vecs[3]  = '{"add_40_02",   ADD,   1'b0, 8'h40, 8'h02, 8'h42, 1'b0, 1'b0, 8'h42};
      vecs[4]  = '{"illegal_c",   4'hC,  1'b0, 8'h11, 8'h22, 8'hFF, 1'b0, 1'b1, 8'h42};
      vecs[5]  = '{"xor_zero",    XOR,   1'b0, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 8'h00};
      vecs[6]  = '{"sub_wrap",    SUB,   1'b0, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 8'hFE};
      vecs[7]  = '{"asr_chain",   ASR,   1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 8'hFF};
      vecs[8]  = '{"lsr_chain",   LSR,   1'b1, 8'h00, 8'h00, 8'h7F, 1'b0, 1'b0, 8'h7F};
      vecs[9]  = '{"notb",        NOTB,  1'b0, 8'h12, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hF0};
      vecs[10] = '{"andn_chain",  ANDN,  1'b1, 8'h00, 8'h30, 8'hC0, 1'b0, 1'b0, 8'hC0};
      vecs[11] = '{"or_0a_50",    OR,    1'b0, 8'h0A, 8'h50, 8'h5A, 1'b0, 1'b0, 8'h5A};
      vecs[12] = '{"add_trunc",   ADD,   1'b1, 8'h00, 8'hA6, 8'h00, 1'b1, 1'b0, 8'h00};
      vecs[13] = '{"illegal_a",   4'hA,  1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 8'h00};
      vecs[14] = '{"sub_chain",   SUB,   1'b1, 8'h55, 8'h01, 8'hFF, 1'b0, 1'b0, 8'hFF};
      vecs[15] = '{"lsl_last_op", 4'h9,  1'b1, 8'h00, 8'h00, 8'hFE, 1'b0, 1'b0, 8'hFE};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_cmd_ready", cmd_ready, 1);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_data", rsp_data, 0);
      checkOutput("rst_rsp_zero", rsp_zero, 0);
      checkOutput("rst_rsp_err", rsp_err, 0);
      checkOutput("rst_acc", acc, 0);
      checkOutput("rst_alu_a", alu_a, 0);
      checkOutput("rst_alu_b", alu_b, 0);
      checkOutput("rst_alu_opcode", alu_opcode, 0);
      checkOutput("rst_busy", busy, 0);
      @(posedge clk);
      #1;

      foreach (vecs[i]) run_vector(vecs[i]);

      // Backpressure: three accepts fill the pipeline plus the two-entry buffer.
      rsp_ready = 1'b0;
      applyStimulus(ADD, 1'b0, 8'h01, 8'h01);
      applyStimulus(ADD, 1'b1, 8'h00, 8'h03);
      applyStimulus(XOR, 1'b1, 8'h00, 8'hFF);
      @(negedge clk);
      checkOutput("bp_cmd_ready_full", cmd_ready, 0);
      cmd_op    = ADD;
      cmd_a     = 8'h77;
      cmd_b     = 8'h77;
      cmd_valid = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("bp_still_full", cmd_ready, 0);
      checkOutput("bp_rsp_valid", rsp_valid, 1);
      checkOutput("bp_rsp_data_held", rsp_data, 8'h02);
      checkOutput("bp_busy", busy, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_rsp("bp_rsp0", 8'h02);
      wait_rsp("bp_rsp1", 8'h05);
      wait_rsp("bp_rsp2", 8'hFA);
      checkOutput("bp_acc", acc, 8'hFA);

      // Reset while the first command is in CAPTURE and the second is buffered.
      applyStimulus(ADD, 1'b0, 8'h10, 8'h20);
      applyStimulus(ADD, 1'b0, 8'h01, 8'h02);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_rsp_valid", rsp_valid, 0);
      checkOutput("midrst_acc", acc, 0);
      checkOutput("midrst_cmd_ready", cmd_ready, 1);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      checkOutput("midrst_no_rsp", seen, 0);
      @(posedge clk);
      #1;

      // Random traffic with random response backpressure, checked by the scoreboard.
      sent = 0;
      for (int cyc = 0; cyc < 4000 && (sent < NRAND || exp_q.size() > 0); cyc++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (!cmd_valid && sent < NRAND && $urandom_range(0, 1) == 1) begin
            cmd_op      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            cmd_use_acc = 1'($urandom_range(0, 1));
            cmd_a       = 8'($urandom_range(0, 255));
            cmd_b       = 8'($urandom_range(0, 255));
            cmd_valid   = 1'b1;
         end
         @(negedge clk);
         accepted = cmd_valid && cmd_ready;
         @(posedge clk);
         #1;
         if (accepted) begin
            sent++;
            cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      checkOutput("rand_all_sent", sent, NRAND);
      checkOutput("rand_queue_drained", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      checkOutput("rand_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
